// File: rtl/param_leaf_router.sv
// param_leaf_router: parametrised leaf router joining one GPU port to NUM_SPINES spine ports.
// Every ingress port has its own FIFO. GPU egress is round-robin arbitrated between the
// spine FIFO heads and the GPU loopback head. Spine egress is fed only by the GPU FIFO.
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   arb_enable                       when low, no new egress loads; valid egress still drains
//   gpu_in_*                         GPU ingress flit (data, dest, valid, ready)
//   gpu_out_*                        GPU egress (data, valid, ready)
//   spine_in_*                       flattened spine ingress; port i at slice i
//   spine_out_*                      flattened spine egress (data, dest, valid, ready)
//   fifo_full, fifo_empty            input FIFO status; bit NUM_SPINES is the GPU FIFO
//   drop_count                       saturating count of misaddressed spine flits
//   current_grant                    requester index of the last GPU egress load
//   busy                             any FIFO non-empty or any egress valid
module param_leaf_router #(
    parameter int          DWIDTH     = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_SPINES = 4,
    parameter logic [3:0]  GROUP_ID   = 4'b0101,
    parameter logic [1:0]  ROUTER_ID  = 2'd0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 arb_enable,
    input  logic [DWIDTH-1:0]                    gpu_in_data,
    input  logic [5:0]                           gpu_in_dest,
    input  logic                                 gpu_in_valid,
    output logic                                 gpu_in_ready,
    output logic [DWIDTH-1:0]                    gpu_out_data,
    output logic                                 gpu_out_valid,
    input  logic                                 gpu_out_ready,
    input  logic [NUM_SPINES*DWIDTH-1:0]         spine_in_data,
    input  logic [NUM_SPINES*6-1:0]              spine_in_dest,
    input  logic [NUM_SPINES-1:0]                spine_in_valid,
    output logic [NUM_SPINES-1:0]                spine_in_ready,
    output logic [NUM_SPINES*DWIDTH-1:0]         spine_out_data,
    output logic [NUM_SPINES*6-1:0]              spine_out_dest,
    output logic [NUM_SPINES-1:0]                spine_out_valid,
    input  logic [NUM_SPINES-1:0]                spine_out_ready,
    output logic [NUM_SPINES:0]                  fifo_full,
    output logic [NUM_SPINES:0]                  fifo_empty,
    output logic [15:0]                          drop_count,
    output logic [$clog2(NUM_SPINES+1)-1:0]      current_grant,
    output logic                                 busy
);
    localparam int NP = NUM_SPINES + 1;
    localparam int SW = $clog2(NUM_SPINES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(NUM_SPINES + 1);
    localparam int FW = DWIDTH + 6;
    localparam logic [5:0] SELF = {GROUP_ID, ROUTER_ID};
    localparam logic [PW:0] PTR_ONE = 1;

    logic [FW-1:0]         in_flit [NP];
    logic [FW-1:0]         head [NP];
    logic [NP-1:0]         push, pop, req;
    logic [NUM_SPINES-1:0] drop_vec, sload;
    logic [GW-1:0]         grant;
    logic                  gload, gpu_local;
    logic [5:0]            gdest;
    logic [SW-1:0]         gpu_tgt;
    logic [16:0]           drop_sum;

    // Flits are stored as {dest, data}; misaddressed spine flits are accepted but never written.
    always_comb begin
        for (int i = 0; i < NUM_SPINES; i++) begin
            in_flit[i]  = {spine_in_dest[i*6 +: 6], spine_in_data[i*DWIDTH +: DWIDTH]};
            push[i]     = spine_in_valid[i] && !fifo_full[i] && spine_in_dest[i*6 +: 6] == SELF;
            drop_vec[i] = spine_in_valid[i] && !fifo_full[i] && spine_in_dest[i*6 +: 6] != SELF;
        end
        in_flit[NUM_SPINES] = {gpu_in_dest, gpu_in_data};
        push[NUM_SPINES]    = gpu_in_valid && !fifo_full[NUM_SPINES];
    end

    assign gpu_in_ready   = !fifo_full[NUM_SPINES];
    assign spine_in_ready = ~fifo_full[NUM_SPINES-1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    for (genvar g = 0; g < NP; g++) begin : g_fifo
        logic [FW-1:0] mem [FIFO_DEPTH];
        logic [PW:0]   wp, rp;
        assign fifo_empty[g] = wp == rp;
        assign fifo_full[g]  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
        assign head[g]       = mem[rp[PW-1:0]];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push[g]) wp <= wp + PTR_ONE;
                if (pop[g])  rp <= rp + PTR_ONE;
            end
        end
        always_ff @(posedge clk) begin
            if (push[g]) mem[wp[PW-1:0]] <= in_flit[g];
        end
    end

    assign gdest     = head[NUM_SPINES][FW-1:DWIDTH];
    assign gpu_local = gdest == SELF;
    assign gpu_tgt   = gdest[SW-1:0];
    assign req       = {!fifo_empty[NUM_SPINES] && gpu_local, ~fifo_empty[NUM_SPINES-1:0]};
    assign gload     = arb_enable && (!gpu_out_valid || gpu_out_ready) && |req;

    // Round-robin: the first requester after the last grant wins.
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = current_grant;
        for (int k = 1; k <= NP; k++) begin
            idx = int'(current_grant) + k;
            if (idx >= NP) idx = idx - NP;
            if (!found && req[idx]) begin
                grant = GW'(idx);
                found = 1'b1;
            end
        end
    end

    // A non-local GPU head waits for its target spine register; the GPU FIFO stalls meanwhile.
    always_comb begin
        for (int j = 0; j < NUM_SPINES; j++) begin
            sload[j] = arb_enable && (!spine_out_valid[j] || spine_out_ready[j]) &&
                       !fifo_empty[NUM_SPINES] && !gpu_local && gpu_tgt == SW'(j);
            pop[j]   = gload && grant == GW'(j);
        end
        pop[NUM_SPINES] = (gload && grant == GW'(NUM_SPINES)) || |sload;
    end

    assign drop_sum = {1'b0, drop_count} + 17'($countones(drop_vec));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpu_out_valid   <= 1'b0;
            gpu_out_data    <= '0;
            spine_out_valid <= '0;
            spine_out_data  <= '0;
            spine_out_dest  <= '0;
            drop_count      <= '0;
            current_grant   <= GW'(NUM_SPINES);
        end else begin
            if (gload) begin
                gpu_out_valid <= 1'b1;
                gpu_out_data  <= head[grant][DWIDTH-1:0];
                current_grant <= grant;
            end else if (gpu_out_ready) begin
                gpu_out_valid <= 1'b0;
            end
            for (int j = 0; j < NUM_SPINES; j++) begin
                if (sload[j]) begin
                    spine_out_valid[j]                  <= 1'b1;
                    spine_out_data[j*DWIDTH +: DWIDTH]  <= head[NUM_SPINES][DWIDTH-1:0];
                    spine_out_dest[j*6 +: 6]            <= gdest;
                end else if (spine_out_ready[j]) begin
                    spine_out_valid[j] <= 1'b0;
                end
            end
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign busy = !(&fifo_empty) || gpu_out_valid || |spine_out_valid;
endmodule

// File: tb/tb_param_leaf_router.sv
// tb_param_leaf_router: directed scenarios plus a randomized run scored against queue-based models.
module tb_param_leaf_router;
    localparam int NS = 4;
    localparam int NP = 5;
    localparam logic [5:0] SELF = 6'h14;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arb_enable = 1'b1;
    logic [15:0]     gpu_in_data = '0;
    logic [5:0]      gpu_in_dest = '0;
    logic            gpu_in_valid = 1'b0;
    logic            gpu_in_ready;
    logic [15:0]     gpu_out_data;
    logic            gpu_out_valid;
    logic            gpu_out_ready = 1'b0;
    logic [NS*16-1:0] spine_in_data = '0;
    logic [NS*6-1:0] spine_in_dest = '0;
    logic [NS-1:0]   spine_in_valid = '0;
    logic [NS-1:0]   spine_in_ready;
    logic [NS*16-1:0] spine_out_data;
    logic [NS*6-1:0] spine_out_dest;
    logic [NS-1:0]   spine_out_valid;
    logic [NS-1:0]   spine_out_ready = '0;
    logic [NS:0]     fifo_full, fifo_empty;
    logic [15:0]     drop_count;
    logic [2:0]      current_grant;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] gq [NP][4096];
    int          gqh [NP];
    int          gqt [NP];
    logic [21:0] sq [NS][4096];
    int          sqh [NS];
    int          sqt [NS];

    always #5 clk = ~clk;

    param_leaf_router #(.DWIDTH(16), .FIFO_DEPTH(8), .NUM_SPINES(NS),
                        .GROUP_ID(4'b0101), .ROUTER_ID(2'd0)) dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable),
        .gpu_in_data(gpu_in_data), .gpu_in_dest(gpu_in_dest), .gpu_in_valid(gpu_in_valid),
        .gpu_in_ready(gpu_in_ready),
        .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
        .spine_in_data(spine_in_data), .spine_in_dest(spine_in_dest),
        .spine_in_valid(spine_in_valid), .spine_in_ready(spine_in_ready),
        .spine_out_data(spine_out_data), .spine_out_dest(spine_out_dest),
        .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count),
        .current_grant(current_grant), .busy(busy)
    );

    task automatic do_reset;
        reset = 1'b0;
        arb_enable = 1'b1;
        gpu_in_valid = 1'b0;
        gpu_in_data = '0;
        gpu_in_dest = '0;
        spine_in_valid = '0;
        spine_in_data = '0;
        spine_in_dest = '0;
        gpu_out_ready = 1'b0;
        spine_out_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (fifo_empty !== 5'h1F) begin miscompares++; $display("FAIL reset_fifo_empty: got %h want 1f", fifo_empty); end
        vectors++; if (fifo_full !== 5'h00) begin miscompares++; $display("FAIL reset_fifo_full: got %h want 00", fifo_full); end
        vectors++; if (gpu_out_valid !== 1'b0 || spine_out_valid !== 4'h0) begin miscompares++; $display("FAIL reset_valids: got gpu %b spine %b want 0", gpu_out_valid, spine_out_valid); end
        vectors++; if (gpu_out_data !== 16'h0 || spine_out_data !== '0 || spine_out_dest !== '0) begin miscompares++; $display("FAIL reset_data: got %h %h %h want 0", gpu_out_data, spine_out_data, spine_out_dest); end
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("FAIL reset_drop_count: got %h want 0", drop_count); end
        vectors++; if (current_grant !== 3'd4) begin miscompares++; $display("FAIL reset_grant: got %0d want 4", current_grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (gpu_in_ready !== 1'b1 || spine_in_ready !== 4'hF) begin miscompares++; $display("FAIL reset_ready: got gpu %b spine %h want 1 f", gpu_in_ready, spine_in_ready); end
    endtask

    task automatic test_gpu_to_spine;
        do_reset;
        gpu_in_data = 16'h1234;
        gpu_in_dest = 6'h2B;
        gpu_in_valid = 1'b1;
        @(negedge clk);
        gpu_in_valid = 1'b0;
        vectors++; if (spine_out_valid !== 4'h0) begin miscompares++; $display("FAIL g2s_early: got %b want 0000", spine_out_valid); end
        @(negedge clk);
        vectors++; if (spine_out_valid !== 4'b1000) begin miscompares++; $display("FAIL g2s_valid: got %b want 1000", spine_out_valid); end
        vectors++; if (spine_out_data[63:48] !== 16'h1234 || spine_out_dest[23:18] !== 6'h2B) begin miscompares++; $display("FAIL g2s_flit: got %h/%h want 1234/2b", spine_out_data[63:48], spine_out_dest[23:18]); end
        vectors++; if (gpu_out_valid !== 1'b0) begin miscompares++; $display("FAIL g2s_gpu_idle: got %b want 0", gpu_out_valid); end
        spine_out_ready = '1;
        @(negedge clk);
        vectors++; if (spine_out_valid !== 4'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL g2s_drain: got valid %b busy %b want 0000 0", spine_out_valid, busy); end
    endtask

    task automatic test_arbitration;
        do_reset;
        gpu_out_ready = 1'b1;
        spine_in_dest = {4{SELF}};
        spine_in_data = {16'h0, 16'hC2C2, 16'h0, 16'hC0C0};
        spine_in_valid = 4'b0101;
        @(negedge clk);
        spine_in_valid = '0;
        @(negedge clk);
        vectors++; if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'hC0C0 || current_grant !== 3'd0) begin miscompares++; $display("FAIL arb_first: got v%b %h g%0d want v1 c0c0 g0", gpu_out_valid, gpu_out_data, current_grant); end
        @(negedge clk);
        vectors++; if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'hC2C2 || current_grant !== 3'd2) begin miscompares++; $display("FAIL arb_second: got v%b %h g%0d want v1 c2c2 g2", gpu_out_valid, gpu_out_data, current_grant); end
        @(negedge clk);
        vectors++; if (gpu_out_valid !== 1'b0) begin miscompares++; $display("FAIL arb_idle: got %b want 0", gpu_out_valid); end
    endtask

    task automatic test_backpressure;
        int accepts;
        int got;
        do_reset;
        accepts = 0;
        got = 0;
        spine_in_dest = {4{SELF}};
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (spine_in_ready[1] && accepts < 12) begin
                spine_in_data[31:16] = 16'hA100 + 16'(accepts);
                spine_in_valid[1] = 1'b1;
                accepts++;
            end else begin
                spine_in_valid[1] = 1'b0;
            end
        end
        vectors++; if (accepts !== 9) begin miscompares++; $display("FAIL bp_accepts: got %0d want 9", accepts); end
        vectors++; if (fifo_full[1] !== 1'b1 || spine_in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL bp_full: got full %b ready %b want 1 0", fifo_full[1], spine_in_ready[1]); end
        gpu_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (gpu_out_valid && got < 12) begin
                vectors++; if (gpu_out_data !== 16'hA100 + 16'(got)) begin miscompares++; $display("FAIL bp_order: got %h want %h", gpu_out_data, 16'hA100 + 16'(got)); end
                got++;
            end
            @(negedge clk);
        end
        vectors++; if (got !== 9 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_delivered: got %0d busy %b want 9 0", got, busy); end
    endtask

    task automatic test_drops;
        int seen;
        do_reset;
        seen = 0;
        gpu_out_ready = 1'b1;
        spine_in_dest = {6'h30, 6'h30, 6'h30, 6'h15};
        for (int c = 0; c < 10; c++) begin
            spine_in_valid = (c < 3) ? 4'b0001 : (c == 3) ? 4'b0110 : 4'b0000;
            @(negedge clk);
            if (gpu_out_valid) seen++;
            if (c == 2) begin
                vectors++; if (drop_count !== 16'd3) begin miscompares++; $display("FAIL drop_partial: got %0d want 3", drop_count); end
            end
        end
        vectors++; if (drop_count !== 16'd5) begin miscompares++; $display("FAIL drop_count: got %0d want 5", drop_count); end
        vectors++; if (seen !== 0 || fifo_empty !== 5'h1F) begin miscompares++; $display("FAIL drop_leak: got seen %0d empty %h want 0 1f", seen, fifo_empty); end
    endtask

    task automatic test_drop_saturation;
        do_reset;
        spine_in_dest = {4{6'h30}};
        spine_in_valid = 4'hF;
        repeat (16383) @(negedge clk);
        vectors++; if (drop_count !== 16'hFFFC) begin miscompares++; $display("FAIL sat_before: got %h want fffc", drop_count); end
        @(negedge clk);
        vectors++; if (drop_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h want ffff", drop_count); end
        @(negedge clk);
        spine_in_valid = '0;
        vectors++; if (drop_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h want ffff", drop_count); end
    endtask

    task automatic test_loopback;
        logic [15:0] seq_got [16];
        logic [2:0]  gnt_got [16];
        logic [15:0] want;
        int n;
        do_reset;
        n = 0;
        gpu_out_ready = 1'b1;
        gpu_in_data = 16'hBEEF;
        gpu_in_dest = SELF;
        spine_in_dest = {4{SELF}};
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            gpu_in_valid = (c == 0);
            spine_in_valid[3] = (c < 8);
            spine_in_data[63:48] = 16'h3000 + 16'(c);
            if (gpu_out_valid && n < 16) begin
                seq_got[n] = gpu_out_data;
                gnt_got[n] = current_grant;
                n++;
            end
        end
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL loop_count: got %0d want 9", n); end
        for (int k = 0; k < 9 && k < n; k++) begin
            want = (k == 0) ? 16'h3000 : (k == 1) ? 16'hBEEF : 16'h3000 + 16'(k - 1);
            vectors++; if (seq_got[k] !== want || gnt_got[k] !== ((k == 1) ? 3'd4 : 3'd3)) begin miscompares++; $display("FAIL loop_seq[%0d]: got %h g%0d want %h g%0d", k, seq_got[k], gnt_got[k], want, (k == 1) ? 4 : 3); end
        end
    endtask

    task automatic test_reset_mid;
        int stale;
        do_reset;
        stale = 0;
        spine_in_dest = {4{SELF}};
        spine_in_valid = 4'b0001;
        @(negedge clk);
        spine_in_valid = '0;
        @(negedge clk);
        vectors++; if (gpu_out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_loaded: got %b want 1", gpu_out_valid); end
        arb_enable = 1'b0;
        spine_in_valid = 4'b1110;
        gpu_in_dest = SELF;
        gpu_in_data = 16'h4444;
        gpu_in_valid = 1'b1;
        @(negedge clk);
        spine_in_valid = '0;
        gpu_in_valid = 1'b0;
        gpu_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (gpu_out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_drain: got %b want 0", gpu_out_valid); end
        vectors++; if (fifo_empty !== 5'b00001 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got empty %b busy %b want 00001 1", fifo_empty, busy); end
        reset = 1'b0;
        #1;
        vectors++; if (gpu_out_valid !== 1'b0 || spine_out_valid !== 4'h0) begin miscompares++; $display("FAIL mid_rst_valid: got %b %b want 0", gpu_out_valid, spine_out_valid); end
        vectors++; if (fifo_empty !== 5'h1F || busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_state: got empty %h busy %b want 1f 0", fifo_empty, busy); end
        @(negedge clk);
        reset = 1'b1;
        arb_enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gpu_out_valid || spine_out_valid != 4'h0) stale++;
        end
        vectors++; if (stale !== 0) begin miscompares++; $display("FAIL mid_stale: got %0d want 0", stale); end
    endtask

    task automatic test_random;
        int seq [NP];
        int drops;
        int s;
        logic hold;
        logic [15:0] held;
        logic [15:0] gexp;
        logic [21:0] sgot, sexp;
        logic [5:0] d;
        do_reset;
        drops = 0;
        hold = 1'b0;
        held = '0;
        for (int i = 0; i < NP; i++) begin seq[i] = 0; gqh[i] = 0; gqt[i] = 0; end
        for (int i = 0; i < NS; i++) begin sqh[i] = 0; sqt[i] = 0; end
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (hold) begin
                vectors++; if (gpu_out_valid !== 1'b1 || gpu_out_data !== held) begin miscompares++; $display("FAIL rnd_stable: got v%b %h want v1 %h", gpu_out_valid, gpu_out_data, held); end
            end
            if (c >= 1500 && !busy) break;
            if (c < 1500) begin
                arb_enable = ($urandom_range(0, 7) != 0);
                gpu_out_ready = ($urandom_range(0, 3) != 0);
                spine_out_ready = 4'($urandom);
                gpu_in_valid = 1'($urandom_range(0, 1));
                gpu_in_data = {4'd4, 12'(seq[4])};
                d = 6'($urandom);
                if ($urandom_range(0, 2) == 0) d = SELF;
                else if (d == SELF) d = 6'h2B;
                gpu_in_dest = d;
                for (int i = 0; i < NS; i++) begin
                    spine_in_valid[i] = 1'($urandom_range(0, 1));
                    spine_in_data[i*16 +: 16] = {4'(i), 12'(seq[i])};
                    spine_in_dest[i*6 +: 6] = ($urandom_range(0, 4) == 0) ? (SELF ^ 6'($urandom_range(1, 63))) : SELF;
                end
            end else begin
                arb_enable = 1'b1;
                gpu_out_ready = 1'b1;
                spine_out_ready = '1;
                gpu_in_valid = 1'b0;
                spine_in_valid = '0;
            end
            if (gpu_in_valid && gpu_in_ready) begin
                if (gpu_in_dest == SELF) begin
                    gq[4][gqt[4] & 4095] = gpu_in_data; gqt[4]++;
                end else begin
                    s = int'(gpu_in_dest[1:0]);
                    sq[s][sqt[s] & 4095] = {gpu_in_dest, gpu_in_data}; sqt[s]++;
                end
                seq[4]++;
            end
            for (int i = 0; i < NS; i++) begin
                if (spine_in_valid[i] && spine_in_ready[i]) begin
                    if (spine_in_dest[i*6 +: 6] == SELF) begin
                        gq[i][gqt[i] & 4095] = spine_in_data[i*16 +: 16]; gqt[i]++;
                    end else begin
                        drops++;
                    end
                    seq[i]++;
                end
            end
            if (gpu_out_valid) begin
                s = int'(gpu_out_data[15:12]);
                vectors++; if (current_grant !== 3'(s)) begin miscompares++; $display("FAIL rnd_grant: got %0d want %0d", current_grant, s); end
                if (gpu_out_ready) begin
                    gexp = (s < NP && gqh[s] != gqt[s]) ? gq[s][gqh[s] & 4095] : 16'hxxxx;
                    vectors++; if (gpu_out_data !== gexp) begin miscompares++; $display("FAIL rnd_gpu_out: got %h want %h", gpu_out_data, gexp); end
                    if (s < NP && gqh[s] != gqt[s]) gqh[s]++;
                end
            end
            hold = gpu_out_valid && !gpu_out_ready;
            held = gpu_out_data;
            for (int j = 0; j < NS; j++) begin
                if (spine_out_valid[j] && spine_out_ready[j]) begin
                    sgot = {spine_out_dest[j*6 +: 6], spine_out_data[j*16 +: 16]};
                    sexp = (sqh[j] != sqt[j]) ? sq[j][sqh[j] & 4095] : 22'hxxxxxx;
                    vectors++; if (sgot !== sexp) begin miscompares++; $display("FAIL rnd_spine_out[%0d]: got %h want %h", j, sgot, sexp); end
                    if (sqh[j] != sqt[j]) sqh[j]++;
                end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rnd_drain_timeout: got busy %b want 0", busy); end
        for (int i = 0; i < NP; i++) begin
            vectors++; if (gqt[i] - gqh[i] !== 0) begin miscompares++; $display("FAIL rnd_gpu_lost[%0d]: got %0d undelivered want 0", i, gqt[i] - gqh[i]); end
        end
        for (int j = 0; j < NS; j++) begin
            vectors++; if (sqt[j] - sqh[j] !== 0) begin miscompares++; $display("FAIL rnd_spine_lost[%0d]: got %0d undelivered want 0", j, sqt[j] - sqh[j]); end
        end
        vectors++; if (drop_count !== 16'(drops)) begin miscompares++; $display("FAIL rnd_drops: got %0d want %0d", drop_count, drops); end
    endtask

    initial begin
        test_reset;
        test_gpu_to_spine;
        test_arbitration;
        test_backpressure;
        test_drops;
        test_drop_saturation;
        test_loopback;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
